// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared arbiter state encoding
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - two-way round-robin picker; on a tie the master that did not win last time goes
module rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    grant_o = 1'b0;
    if (req_i == 2'b11) begin
      grant_o = ~last_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter in front of one BRAM port
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int ADDR_BITS      = 10,
  parameter  int BYTE_BITS      = 8,
  parameter  int BYTES_PER_WORD = 4,
  parameter  int TIMEOUT        = 15,
  localparam int WORD_BITS      = BYTE_BITS * BYTES_PER_WORD
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [ADDR_BITS-1:0]      m0_addr,
  input  logic [WORD_BITS-1:0]      m0_in,
  output logic [WORD_BITS-1:0]      m0_out,
  input  logic [BYTES_PER_WORD-1:0] m0_select,
  input  logic                      m0_write,
  input  logic                      m0_strobe,
  output logic                      m0_ack,
  output logic                      m0_retry,
  input  logic [ADDR_BITS-1:0]      m1_addr,
  input  logic [WORD_BITS-1:0]      m1_in,
  output logic [WORD_BITS-1:0]      m1_out,
  input  logic [BYTES_PER_WORD-1:0] m1_select,
  input  logic                      m1_write,
  input  logic                      m1_strobe,
  output logic                      m1_ack,
  output logic                      m1_retry,
  output logic [ADDR_BITS-1:0]      s_addr,
  output logic [WORD_BITS-1:0]      s_in,
  input  logic [WORD_BITS-1:0]      s_out,
  output logic [BYTES_PER_WORD-1:0] s_select,
  output logic                      s_write,
  output logic                      s_strobe,
  input  logic                      s_ack,
  input  logic                      s_retry
);

  typedef struct packed {
    logic [ADDR_BITS-1:0]      addr;
    logic [WORD_BITS-1:0]      wdata;
    logic [BYTES_PER_WORD-1:0] select;
    logic                      write;
  } req_t;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   owner_q, owner_d;
  logic   strobe_q, strobe_d;
  req_t   req_q, req_d;
  req_t   m0_req, m1_req;
  logic   grant, grant_valid;
  logic   timeout_hit, done_ack, done_retry, in_wait;

  assign m0_req = {m0_addr, m0_in, m0_select, m0_write};
  assign m1_req = {m1_addr, m1_in, m1_select, m1_write};

  rr_pick u_pick (
    .req_i  ({m1_strobe, m0_strobe}),
    .last_i (last_q),
    .grant_o(grant),
    .valid_o(grant_valid)
  );

  // Watchdog counts WAIT cycles; it only exists when a timeout is configured.
  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int WD_BITS = $clog2(TIMEOUT + 1);
      logic [WD_BITS-1:0] wd_q, wd_d;

      always_comb begin
        wd_d = wd_q;
        if (state_q == ISSUE) begin
          wd_d = '0;
        end else if (state_q == WAIT) begin
          wd_d = wd_q + 1'b1;
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          wd_q <= '0;
        end else begin
          wd_q <= wd_d;
        end
      end

      assign timeout_hit = (state_q == WAIT) && (wd_q == WD_BITS'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign in_wait    = (state_q == WAIT);
  assign done_ack   = in_wait && s_ack;
  assign done_retry = in_wait && !s_ack && (s_retry || timeout_hit);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    strobe_d = 1'b0;
    req_d    = req_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_d    = grant ? m1_req : m0_req;
          strobe_d = 1'b1;
          owner_d  = grant;
          last_d   = grant;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done_ack || done_retry) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      strobe_q <= 1'b0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      strobe_q <= strobe_d;
      req_q    <= req_d;
    end
  end

  assign s_addr   = req_q.addr;
  assign s_in     = req_q.wdata;
  assign s_select = req_q.select;
  assign s_write  = req_q.write;
  assign s_strobe = strobe_q;

  // Only the owner sees slave data and completion pulses.
  assign m0_out   = (in_wait && !owner_q) ? s_out : '0;
  assign m1_out   = (in_wait &&  owner_q) ? s_out : '0;
  assign m0_ack   = done_ack   && !owner_q;
  assign m1_ack   = done_ack   &&  owner_q;
  assign m0_retry = done_retry && !owner_q;
  assign m1_retry = done_retry &&  owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter with a BRAM slave model
module tb_bus_arbiter;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [1:0] MA = 2'd0;  // slave acks
  localparam logic [1:0] MR = 2'd1;  // slave retries
  localparam logic [1:0] MB = 2'd2;  // slave asserts ack and retry
  localparam logic [1:0] MN = 2'd3;  // slave silent

  logic        clock, reset_n;
  logic [9:0]  m0_addr, m1_addr, s_addr;
  logic [31:0] m0_in, m1_in, m0_out, m1_out, s_in, s_out;
  logic [3:0]  m0_select, m1_select, s_select;
  logic        m0_write, m0_strobe, m0_ack, m0_retry;
  logic        m1_write, m1_strobe, m1_ack, m1_retry;
  logic        s_write, s_strobe, s_ack, s_retry;

  logic [31:0] mem [0:1023];
  logic [1:0]  mode;
  logic        late_ack;
  int          n_vec, n_bad;

  typedef struct packed {
    logic        m0_stb; logic m0_wr; logic [9:0] m0_addr; logic [31:0] m0_wd; logic [3:0] m0_sel;
    logic        m1_stb; logic m1_wr; logic [9:0] m1_addr; logic [31:0] m1_wd; logic [3:0] m1_sel;
    logic [1:0]  mode;
    logic        e_stb; logic [9:0] e_addr; logic e_wr; logic [3:0] e_sel;
    logic        e_m0_ack; logic e_m0_rty; logic [31:0] e_m0_out;
    logic        e_m1_ack; logic e_m1_rty; logic [31:0] e_m1_out;
  } vec_t;

  vec_t vt [24];

  bus_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_in(m0_in), .m0_out(m0_out), .m0_select(m0_select),
    .m0_write(m0_write), .m0_strobe(m0_strobe), .m0_ack(m0_ack), .m0_retry(m0_retry),
    .m1_addr(m1_addr), .m1_in(m1_in), .m1_out(m1_out), .m1_select(m1_select),
    .m1_write(m1_write), .m1_strobe(m1_strobe), .m1_ack(m1_ack), .m1_retry(m1_retry),
    .s_addr(s_addr), .s_in(s_in), .s_out(s_out), .s_select(s_select),
    .s_write(s_write), .s_strobe(s_strobe), .s_ack(s_ack), .s_retry(s_retry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: the slave sees s_* as registered before the edge and answers in the following cycle.
  task automatic cyc();
    logic       p_stb, p_wr;
    logic [9:0] p_addr;
    logic [31:0] p_wd;
    logic [3:0] p_sel;
    p_stb = s_strobe; p_wr = s_write; p_addr = s_addr; p_wd = s_in; p_sel = s_select;
    @(posedge clock);
    #1;
    s_ack = late_ack; s_retry = 1'b0; s_out = 32'h0; late_ack = 1'b0;
    if (p_stb) begin
      if (mode == MA || mode == MB) begin
        if (p_wr) begin
          for (int b = 0; b < 4; b++)
            if (p_sel[b]) mem[p_addr][8*b +: 8] = p_wd[8*b +: 8];
        end
        s_out = mem[p_addr];
        s_ack = 1'b1;
        s_retry = (mode == MB);
      end else if (mode == MR) begin
        s_retry = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    int first, nret, nack;
    n_vec = 0; n_bad = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h010] = 32'hDEADBEEF;
    mem[10'h020] = 32'hCAFEF00D;
    mem[10'h021] = 32'h01234567;
    mem[10'h3FF] = 32'h11223344;

    vt[0]  = '{T,F,10'h010,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MA, T,10'h010,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[1]  = '{T,F,10'h010,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MA, F,10'h010,F,4'hF, T,F,32'hDEADBEEF, F,F,32'h0};
    vt[2]  = '{F,F,10'h010,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MA, F,10'h010,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[3]  = '{T,F,10'h020,32'h0,4'hF,        T,F,10'h021,32'h0,4'hF,       MA, T,10'h021,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[4]  = '{T,F,10'h020,32'h0,4'hF,        T,F,10'h021,32'h0,4'hF,       MA, F,10'h021,F,4'hF, F,F,32'h0,        T,F,32'h01234567};
    vt[5]  = '{T,F,10'h020,32'h0,4'hF,        F,F,10'h021,32'h0,4'hF,       MA, F,10'h021,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[6]  = '{T,F,10'h020,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MA, T,10'h020,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[7]  = '{T,F,10'h020,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MA, F,10'h020,F,4'hF, T,F,32'hCAFEF00D, F,F,32'h0};
    vt[8]  = '{F,F,10'h020,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MA, F,10'h020,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[9]  = '{F,F,10'h000,32'h0,4'h0,        T,T,10'h3FF,32'hA5A5A5A5,4'h3, MA, T,10'h3FF,T,4'h3, F,F,32'h0,        F,F,32'h0};
    vt[10] = '{F,F,10'h000,32'h0,4'h0,        T,T,10'h3FF,32'hA5A5A5A5,4'h3, MA, F,10'h3FF,T,4'h3, F,F,32'h0,        T,F,32'h1122A5A5};
    vt[11] = '{F,F,10'h000,32'h0,4'h0,        F,T,10'h3FF,32'hA5A5A5A5,4'h3, MA, F,10'h3FF,T,4'h3, F,F,32'h0,        F,F,32'h0};
    vt[12] = '{F,F,10'h000,32'h0,4'h0,        T,F,10'h3FF,32'h0,4'hF,       MA, T,10'h3FF,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[13] = '{F,F,10'h000,32'h0,4'h0,        T,F,10'h3FF,32'h0,4'hF,       MA, F,10'h3FF,F,4'hF, F,F,32'h0,        T,F,32'h1122A5A5};
    vt[14] = '{F,F,10'h000,32'h0,4'h0,        F,F,10'h3FF,32'h0,4'hF,       MA, F,10'h3FF,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[15] = '{T,T,10'h020,32'hFFFFFFFF,4'h0, F,F,10'h000,32'h0,4'h0,       MA, T,10'h020,T,4'h0, F,F,32'h0,        F,F,32'h0};
    vt[16] = '{T,T,10'h020,32'hFFFFFFFF,4'h0, F,F,10'h000,32'h0,4'h0,       MA, F,10'h020,T,4'h0, T,F,32'hCAFEF00D, F,F,32'h0};
    vt[17] = '{F,T,10'h020,32'hFFFFFFFF,4'h0, F,F,10'h000,32'h0,4'h0,       MA, F,10'h020,T,4'h0, F,F,32'h0,        F,F,32'h0};
    vt[18] = '{T,F,10'h010,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MR, T,10'h010,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[19] = '{T,F,10'h010,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MR, F,10'h010,F,4'hF, F,T,32'h0,        F,F,32'h0};
    vt[20] = '{F,F,10'h010,32'h0,4'hF,        F,F,10'h000,32'h0,4'h0,       MR, F,10'h010,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[21] = '{F,F,10'h000,32'h0,4'h0,        T,F,10'h021,32'h0,4'hF,       MB, T,10'h021,F,4'hF, F,F,32'h0,        F,F,32'h0};
    vt[22] = '{F,F,10'h000,32'h0,4'h0,        T,F,10'h021,32'h0,4'hF,       MB, F,10'h021,F,4'hF, F,F,32'h0,        T,F,32'h01234567};
    vt[23] = '{F,F,10'h000,32'h0,4'h0,        F,F,10'h021,32'h0,4'hF,       MB, F,10'h021,F,4'hF, F,F,32'h0,        F,F,32'h0};

    reset_n = 1'b0; mode = MA; late_ack = 1'b0;
    s_ack = 1'b0; s_retry = 1'b0; s_out = 32'h0;
    m0_strobe = 1'b0; m0_write = 1'b0; m0_addr = 10'h0; m0_in = 32'h0; m0_select = 4'h0;
    m1_strobe = 1'b0; m1_write = 1'b0; m1_addr = 10'h0; m1_in = 32'h0; m1_select = 4'h0;
    repeat (2) @(negedge clock);
    chk("rst s_strobe", 32'(s_strobe), 32'h0);
    chk("rst s_addr",   32'(s_addr),   32'h0);
    chk("rst s_select", 32'(s_select), 32'h0);
    chk("rst s_write",  32'(s_write),  32'h0);
    chk("rst acks",     32'({m0_ack, m1_ack, m0_retry, m1_retry}), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      m0_strobe = vt[i].m0_stb; m0_write = vt[i].m0_wr; m0_addr = vt[i].m0_addr;
      m0_in = vt[i].m0_wd; m0_select = vt[i].m0_sel;
      m1_strobe = vt[i].m1_stb; m1_write = vt[i].m1_wr; m1_addr = vt[i].m1_addr;
      m1_in = vt[i].m1_wd; m1_select = vt[i].m1_sel;
      mode = vt[i].mode;
      cyc();
      chk($sformatf("v%0d s_strobe", i), 32'(s_strobe), 32'(vt[i].e_stb));
      chk($sformatf("v%0d s_addr", i),   32'(s_addr),   32'(vt[i].e_addr));
      chk($sformatf("v%0d s_write", i),  32'(s_write),  32'(vt[i].e_wr));
      chk($sformatf("v%0d s_select", i), 32'(s_select), 32'(vt[i].e_sel));
      chk($sformatf("v%0d m0_ack", i),   32'(m0_ack),   32'(vt[i].e_m0_ack));
      chk($sformatf("v%0d m0_retry", i), 32'(m0_retry), 32'(vt[i].e_m0_rty));
      chk($sformatf("v%0d m0_out", i),   m0_out,        vt[i].e_m0_out);
      chk($sformatf("v%0d m1_ack", i),   32'(m1_ack),   32'(vt[i].e_m1_ack));
      chk($sformatf("v%0d m1_retry", i), 32'(m1_retry), 32'(vt[i].e_m1_rty));
      chk($sformatf("v%0d m1_out", i),   m1_out,        vt[i].e_m1_out);
    end

    // Contention from reset exit: m0 first, then strict alternation every three cycles.
    reset_n = 1'b0; mode = MA;
    m0_strobe = 1'b1; m0_write = 1'b0; m0_addr = 10'h010; m0_select = 4'hF;
    m1_strobe = 1'b1; m1_write = 1'b0; m1_addr = 10'h3FF; m1_select = 4'hF;
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("rr%0d s_strobe", k), 32'(s_strobe), 32'h1);
      chk($sformatf("rr%0d s_addr", k), 32'(s_addr), (k % 2 == 0) ? 32'h010 : 32'h3FF);
      cyc();
      chk($sformatf("rr%0d m0_ack", k), 32'(m0_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr%0d m1_ack", k), 32'(m1_ack), (k % 2 == 1) ? 32'h1 : 32'h0);
      chk($sformatf("rr%0d data", k), (k % 2 == 0) ? m0_out : m1_out,
          (k % 2 == 0) ? 32'hDEADBEEF : 32'h1122A5A5);
      cyc();
    end

    // Silent slave: watchdog retry 15 cycles after ISSUE, then a late ack is dropped.
    m1_strobe = 1'b0; m0_strobe = 1'b1; m0_addr = 10'h010; mode = MN;
    cyc();
    chk("wd issue", 32'(s_strobe), 32'h1);
    first = 0; nret = 0; nack = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (m0_retry) begin
        nret++;
        if (first == 0) first = i;
        m0_strobe = 1'b0;
      end
      if (m0_ack) nack++;
    end
    chk("wd retry cycle", 32'(first), 32'd15);
    chk("wd retry count", 32'(nret), 32'd1);
    chk("wd no ack", 32'(nack), 32'd0);
    late_ack = 1'b1;
    cyc();
    chk("late ack m0_ack", 32'(m0_ack), 32'h0);
    chk("late ack m0_retry", 32'(m0_retry), 32'h0);
    cyc();
    chk("late ack idle", 32'(s_strobe), 32'h0);

    // Asynchronous reset while m1 is in WAIT with a live ack.
    mode = MA; m1_strobe = 1'b1; m1_addr = 10'h021; m1_write = 1'b0; m1_select = 4'hF;
    cyc();
    chk("ar s_addr", 32'(s_addr), 32'h021);
    cyc();
    chk("ar m1_ack pre", 32'(m1_ack), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar s_addr", 32'(s_addr), 32'h0);
    chk("ar s_select", 32'(s_select), 32'h0);
    chk("ar m1_ack", 32'(m1_ack), 32'h0);
    chk("ar m1_out", m1_out, 32'h0);
    m0_strobe = 1'b1; m0_addr = 10'h010;
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    chk("ar first grant strobe", 32'(s_strobe), 32'h1);
    chk("ar first grant addr", 32'(s_addr), 32'h010);
    cyc();
    chk("ar first grant ack", 32'(m0_ack), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
